// File: rtl/relay_mode_sequencer_pkg.sv
// Mode encodings, sequencer states and the relay-mode decode shared by the
// mode sequencer and the relay path.
package relay_mode_sequencer_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SWC_W  = 8;

    localparam logic [MODE_W-1:0] MODE_SNIFFER       = 3'b000;
    localparam logic [MODE_W-1:0] MODE_TAGSIM_LISTEN = 3'b001;
    localparam logic [MODE_W-1:0] MODE_TAGSIM_MOD    = 3'b010;
    localparam logic [MODE_W-1:0] MODE_READER_LISTEN = 3'b011;
    localparam logic [MODE_W-1:0] MODE_READER_MOD    = 3'b100;
    localparam logic [MODE_W-1:0] MODE_FAKE_READER   = 3'b101;
    localparam logic [MODE_W-1:0] MODE_FAKE_TAG      = 3'b110;
    localparam logic [MODE_W-1:0] MODE_RELAY_TEST    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'b00,
        ST_WAIT_BOUNDARY = 2'b01,
        ST_GUARD         = 2'b10
    } seq_state_t;

    // Fake reader, fake tag and relay test all route through the relay path.
    function automatic logic is_relay_mode(input logic [MODE_W-1:0] mode);
        return (mode == MODE_FAKE_READER) || (mode == MODE_FAKE_TAG) ||
               (mode == MODE_RELAY_TEST);
    endfunction

endpackage

// File: rtl/mode_guard_timer.sv
// Loadable down-counter; done_c flags the enabled cycle in which it sits at zero.
module mode_guard_timer
    import relay_mode_sequencer_pkg::*;
(
    input  logic             ck_1356meg,
    input  logic             nrst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             done_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done_c = enable && (count == '0);

endmodule

// File: rtl/relay_mode_sequencer.sv
// Defers modulation mode changes to a frame boundary (or timeout) and then
// holds the carrier quiet for a guard interval before applying the new mode.
module relay_mode_sequencer
    import relay_mode_sequencer_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES     = 128,
    parameter int unsigned BOUNDARY_TIMEOUT = 4096
) (
    input  logic              ck_1356meg,
    input  logic              nrst,
    input  logic              conf_strobe,
    input  logic [MODE_W-1:0] conf_mod_type,
    input  logic              frame_boundary,
    output logic [MODE_W-1:0] mod_type,
    output logic              relay_active,
    output logic              carrier_hold,
    output logic              busy,
    output logic              overrun,
    output logic [SWC_W-1:0]  switch_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(BOUNDARY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(GUARD_CYCLES - 1);

    seq_state_t        state;
    logic [MODE_W-1:0] pending;

    logic start_c;
    logic timeout_done_c;
    logic guard_load_c;
    logic guard_done_c;
    logic [MODE_W-1:0] final_mode_c;

    assign start_c      = (state == ST_IDLE) && conf_strobe && (conf_mod_type != mod_type);
    assign guard_load_c = (state == ST_WAIT_BOUNDARY) && (frame_boundary || timeout_done_c);
    // A request landing on the last guard cycle still wins.
    assign final_mode_c = conf_strobe ? conf_mod_type : pending;

    mode_guard_timer u_timeout (
        .ck_1356meg (ck_1356meg),
        .nrst       (nrst),
        .load       (start_c),
        .load_value (TIMEOUT_LOAD),
        .enable     (state == ST_WAIT_BOUNDARY),
        .done_c     (timeout_done_c)
    );

    mode_guard_timer u_guard (
        .ck_1356meg (ck_1356meg),
        .nrst       (nrst),
        .load       (guard_load_c),
        .load_value (GUARD_LOAD),
        .enable     (state == ST_GUARD),
        .done_c     (guard_done_c)
    );

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            state        <= ST_IDLE;
            pending      <= MODE_SNIFFER;
            mod_type     <= MODE_SNIFFER;
            relay_active <= 1'b0;
            carrier_hold <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            switch_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        pending <= conf_mod_type;
                        busy    <= 1'b1;
                        state   <= ST_WAIT_BOUNDARY;
                    end
                end
                ST_WAIT_BOUNDARY: begin
                    if (conf_strobe) begin
                        pending <= conf_mod_type;
                        overrun <= 1'b1;
                    end
                    if (guard_load_c) begin
                        mod_type     <= MODE_SNIFFER;
                        relay_active <= 1'b0;
                        carrier_hold <= 1'b1;
                        state        <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (conf_strobe) begin
                        pending <= conf_mod_type;
                        overrun <= 1'b1;
                    end
                    if (guard_done_c) begin
                        mod_type     <= final_mode_c;
                        relay_active <= is_relay_mode(final_mode_c);
                        carrier_hold <= 1'b0;
                        busy         <= 1'b0;
                        switch_count <= switch_count + SWC_W'(1);
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relay_mode_sequencer.sv
// Directed bench for relay_mode_sequencer with default guard/timeout lengths.
module tb_relay_mode_sequencer;

    logic       ck_1356meg = 1'b0;
    logic       nrst = 1'b0;
    logic       conf_strobe = 1'b0;
    logic [2:0] conf_mod_type = 3'b000;
    logic       frame_boundary = 1'b0;
    logic [2:0] mod_type;
    logic       relay_active;
    logic       carrier_hold;
    logic       busy;
    logic       overrun;
    logic [7:0] switch_count;

    int vectors = 0;
    int miscompares = 0;
    int hold_cnt;

    relay_mode_sequencer #(
        .GUARD_CYCLES     (128),
        .BOUNDARY_TIMEOUT (4096)
    ) dut (
        .ck_1356meg     (ck_1356meg),
        .nrst           (nrst),
        .conf_strobe    (conf_strobe),
        .conf_mod_type  (conf_mod_type),
        .frame_boundary (frame_boundary),
        .mod_type       (mod_type),
        .relay_active   (relay_active),
        .carrier_hold   (carrier_hold),
        .busy           (busy),
        .overrun        (overrun),
        .switch_count   (switch_count)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge ck_1356meg);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Count consecutive carrier_hold samples, the current one included.
    task automatic measure_hold(input int already, output int cnt);
        cnt = already;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (carrier_hold) cnt++;
            else break;
        end
    endtask

    task automatic pulse_strobe(input logic [2:0] mode);
        conf_strobe   = 1'b1;
        conf_mod_type = mode;
        tick();
        conf_strobe   = 1'b0;
    endtask

    task automatic pulse_boundary();
        frame_boundary = 1'b1;
        tick();
        frame_boundary = 1'b0;
    endtask

    initial begin
        // Reset
        nrst = 1'b0;
        tick();
        tick();
        check("rst_mod", 32'(mod_type), 32'h0);
        check("rst_relay", 32'(relay_active), 32'h0);
        check("rst_hold", 32'(carrier_hold), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_count", 32'(switch_count), 32'h0);
        nrst = 1'b1;
        tick();

        // 1: basic switch to 100, boundary 10 cycles after the strobe
        pulse_strobe(3'b100);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_mod_wait", 32'(mod_type), 32'h0);
        repeat (9) tick();
        check("t1_hold_pre", 32'(carrier_hold), 32'h0);
        pulse_boundary();
        check("t1_hold_on", 32'(carrier_hold), 32'h1);
        measure_hold(1, hold_cnt);
        check("t1_hold_len", 32'(hold_cnt), 32'd128);
        check("t1_mod", 32'(mod_type), 32'h4);
        check("t1_relay", 32'(relay_active), 32'h0);
        check("t1_count", 32'(switch_count), 32'h1);
        check("t1_busy_end", 32'(busy), 32'h0);

        // 2: same-mode request and stray boundary are ignored
        pulse_strobe(3'b100);
        check("t2_busy", 32'(busy), 32'h0);
        pulse_boundary();
        check("t2_busy2", 32'(busy), 32'h0);
        check("t2_count", 32'(switch_count), 32'h1);
        check("t2_hold", 32'(carrier_hold), 32'h0);

        // 3: timeout path to 101
        pulse_strobe(3'b101);
        repeat (4095) tick();
        check("t3_hold_pre", 32'(carrier_hold), 32'h0);
        check("t3_busy", 32'(busy), 32'h1);
        tick();
        check("t3_hold_on", 32'(carrier_hold), 32'h1);
        check("t3_mod_guard", 32'(mod_type), 32'h0);
        repeat (127) tick();
        check("t3_hold_last", 32'(carrier_hold), 32'h1);
        tick();
        check("t3_mod", 32'(mod_type), 32'h5);
        check("t3_relay", 32'(relay_active), 32'h1);
        check("t3_count", 32'(switch_count), 32'h2);

        // 4: overrun mid-guard, latest request wins, guard not restarted
        pulse_strobe(3'b011);
        pulse_boundary();
        repeat (50) tick();
        pulse_strobe(3'b110);
        check("t4_overrun", 32'(overrun), 32'h1);
        check("t4_mod_guard", 32'(mod_type), 32'h0);
        measure_hold(52, hold_cnt);
        check("t4_hold_len", 32'(hold_cnt), 32'd128);
        check("t4_mod", 32'(mod_type), 32'h6);
        check("t4_relay", 32'(relay_active), 32'h1);
        check("t4_count", 32'(switch_count), 32'h3);

        // 5: reset mid-guard
        pulse_strobe(3'b001);
        pulse_boundary();
        repeat (10) tick();
        check("t5_hold_pre", 32'(carrier_hold), 32'h1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("t5_hold", 32'(carrier_hold), 32'h0);
        check("t5_mod", 32'(mod_type), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_overrun", 32'(overrun), 32'h0);
        check("t5_count", 32'(switch_count), 32'h0);
        repeat (200) tick();
        check("t5_discard_mod", 32'(mod_type), 32'h0);
        check("t5_discard_busy", 32'(busy), 32'h0);

        // 6: 255 alternating switches, then a 256th with strobe+boundary together
        for (int i = 0; i < 255; i++) begin
            pulse_strobe((i % 2 == 0) ? 3'b010 : 3'b000);
            pulse_boundary();
            repeat (128) tick();
        end
        check("t6_count255", 32'(switch_count), 32'hff);
        check("t6_mod255", 32'(mod_type), 32'h2);
        pulse_strobe(3'b011);
        conf_strobe    = 1'b1;
        conf_mod_type  = 3'b111;
        frame_boundary = 1'b1;
        tick();
        conf_strobe    = 1'b0;
        frame_boundary = 1'b0;
        check("t6_hold_on", 32'(carrier_hold), 32'h1);
        check("t6_overrun", 32'(overrun), 32'h1);
        repeat (127) tick();
        check("t6_hold_last", 32'(carrier_hold), 32'h1);
        tick();
        check("t6_mod", 32'(mod_type), 32'h7);
        check("t6_relay", 32'(relay_active), 32'h1);
        check("t6_count_wrap", 32'(switch_count), 32'h0);
        check("t6_hold_off", 32'(carrier_hold), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
